interleaver_ctrl: RTL and testbench
===================================

# interleaver_ctrl

Control and sequencing engine for the ping-pong block (de)interleaver memory.
- Accepts a symbol stream with a valid/ready handshake and produces write and read strobes, bank selects and permuted addresses for an external two-bank ROWS×COLS buffer.
- Emits a handshaked, frame-marked output stream with backpressure.
- Sits between the channel coder/demapper and the bank memory and replaces free-running counter/flag sequencing.

## Interface
- ROWS, 4, matrix rows (≥2)
- COLS, 4, matrix columns (≥2); N = ROWS*COLS symbols per frame, AW = clog2(N)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = interleave, 1 = deinterleave; sampled on the first accepted symbol of each frame
- in_valid  in  1  input symbol present
- in_sof  in  1  qualifies the symbol as first of a frame (optional)
- in_ready  out  1  controller can accept a symbol
- wr_en  out  1  write strobe (= in_valid & in_ready)
- wr_bank  out  1  bank being filled
- wr_addr  out  AW  write address
- rd_en  out  1  read strobe; memory presents data one cycle later and holds it while rd_en=0
- rd_bank  out  1  bank being drained
- rd_addr  out  AW  permuted read address
- out_valid  out  1  memory read data is valid
- out_sof  out  1  accompanies out_valid on the first symbol of a frame
- out_ready  in  1  downstream accepts
- sync_err  out  1  one-cycle pulse on mid-frame resynchronisation

## Operation
- State registers: `full[1:0]`, `wr_bank`, `wr_cnt`, `rd_bank`, read row counter `r`, read column counter `c`, `bank_mode[1:0]`, `out_valid`, `out_sof`.
- Write side:
  - in_ready = !full[wr_bank]; wr_addr = wr_cnt (sequential).
  - On wr_en: wr_cnt increments. When wr_cnt = 0, mode is latched into bank_mode[wr_bank].
  - On wr_en with wr_cnt = N-1: full[wr_bank] is set, wr_bank toggles and wr_cnt wraps to 0.
- Resynchronisation:
  - When wr_en, in_sof=1 and wr_cnt≠0, the partial fill is discarded.
  - That symbol is written at address 0 of the same bank, wr_cnt becomes 1, mode is re-latched and sync_err pulses.
  - in_sof with wr_cnt = 0 is normal.
- Read side:
  - rd_en = full[rd_bank] & (!out_valid | out_ready).
  - Interleave (bank_mode=0): c is the outer loop, r the inner loop; rd_addr = r*COLS + c.
  - Deinterleave (bank_mode=1): r is the outer loop, c the inner loop; rd_addr = c*ROWS + r.
  - For 4×4 both modes give 0,4,8,12,1,5,…,15.
  - On rd_en for the last address (r=ROWS-1,c=COLS-1): full[rd_bank] clears, rd_bank toggles and the counters return to 0.
- Output register:
  - out_valid is set on rd_en and cleared when out_ready & !rd_en.
  - out_sof is loaded on rd_en with (r=0 & c=0) and held otherwise.
- Simultaneous events:
  - Set and clear of the same full bit in one cycle cannot occur. Write only targets a non-full bank; read only targets a full bank.
  - Fill and drain of opposite banks proceed concurrently at one symbol per cycle each.
- Both banks full: in_ready=0 until the drain of rd_bank completes.
- Both banks empty: rd_en=0, and out_valid falls after its last symbol is taken.

## Timing
- Reset values: full=0, wr_bank=0, rd_bank=0, counters=0, bank_mode=0, out_valid=0, out_sof=0, sync_err=0, hence in_ready=1, wr_en=0, rd_en=0, wr_addr=0, rd_addr=0.
- Reset asserted mid-frame discards all partial and full banks immediately.
- Last write at cycle t: full set at t+1, first rd_en at t+1, first out_valid with out_sof at t+2.
- Frame latency from first accepted symbol is N+1 cycles at full rate.
- Sustained throughput is 1 symbol/cycle in both directions with out_ready=1.
- out_valid/out_sof hold stable while out_ready=0. rd_en never asserts while a symbol is pending and not taken.
- sync_err is high for exactly one cycle, the cycle after the offending write.

## Structure
- Shared package `interleaver_pkg`:
  - default ROWS/COLS;
  - AW derivation function;
  - mode encoding constants MODE_ILV=0, MODE_DEILV=1.
- Sub-module `interleaver_rd_addr_gen` holds:
  - the nested r/c counters;
  - the mode-dependent address arithmetic (multiply by constant, no divider);
  - the advance input and a last flag.

## Test plan
- 4×4, mode=0, symbols 0..15 continuous, out_ready=1 -> rd_addr 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_sof on first; first out_valid 2 cycles after last write.
- ROWS=2, COLS=4, mode=1, 8 symbols -> rd_addr 0,2,4,6,1,3,5,7; repeat with mode=0 -> 0,4,1,5,2,6,3,7.
- Three back-to-back frames, out_ready=1 -> in_ready never drops, banks alternate 0,1,0, and output is gap-free after the first frame.
- out_ready=0 held -> in_ready falls after exactly 2N accepted symbols. Release -> outputs resume, none lost or duplicated.
- in_sof at wr_cnt=9 -> sync_err pulses once, and the frame completes 15 writes later at addresses 1..15 of the same bank.
- rst low while both banks are full and out_valid=1 -> all outputs return to reset values asynchronously. A fresh frame after release processes normally.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared parameters, mode encodings and width helper for the ping-pong
// (de)interleaver controller and its read address generator.
package interleaver_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;

  localparam logic MODE_ILV   = 1'b0;
  localparam logic MODE_DEILV = 1'b1;

  // Width of a counter/address spanning 0..n-1, never narrower than one bit.
  function automatic int calc_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/interleaver_ctrl_if.sv
// Handshake and memory-control bundle between the controller and its
// neighbours; master drives the symbol stream, slave is the controller.
interface interleaver_ctrl_if #(parameter int AW = 4);

  logic          mode;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          out_sof;
  logic          out_ready;
  logic          sync_err;

  modport master (
    output mode, in_valid, in_sof, out_ready,
    input  in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           out_valid, out_sof, sync_err
  );

  modport slave (
    input  mode, in_valid, in_sof, out_ready,
    output in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
           out_valid, out_sof, sync_err
  );

endinterface

// File: rtl/interleaver_rd_addr_gen.sv
// Nested row/column counters producing the permuted read address; the loop
// order and address arithmetic follow the mode of the bank being drained.
module interleaver_rd_addr_gen
  import interleaver_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int AW   = calc_aw(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance_i,
  input  logic          mode_i,
  output logic [AW-1:0] addr_o,
  output logic          first_o,
  output logic          last_o
);

  localparam int RW = calc_aw(ROWS);
  localparam int CW = calc_aw(COLS);

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          rEnd, cEnd;

  assign rEnd = (r_q == RW'(ROWS - 1));
  assign cEnd = (c_q == CW'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  // Interleave runs rows fastest, deinterleave runs columns fastest.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (advance_i) begin
      if (mode_i == MODE_ILV) begin
        r_d = rEnd ? '0 : r_q + RW'(1);
        if (rEnd) c_d = cEnd ? '0 : c_q + CW'(1);
      end else begin
        c_d = cEnd ? '0 : c_q + CW'(1);
        if (cEnd) r_d = rEnd ? '0 : r_q + RW'(1);
      end
    end
  end

  always_comb begin
    if (mode_i == MODE_ILV) addr_o = AW'(r_q) * AW'(COLS) + AW'(c_q);
    else                    addr_o = AW'(c_q) * AW'(ROWS) + AW'(r_q);
  end

  assign first_o = (r_q == '0) && (c_q == '0);
  assign last_o  = rEnd && cEnd;

endmodule

// File: rtl/interleaver_ctrl.sv
// Ping-pong bank sequencer: fills one bank sequentially while draining the
// other in permuted order, with a registered, backpressured output flag.
module interleaver_ctrl
  import interleaver_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input logic               clk,
  input logic               rst_n,
  interleaver_ctrl_if.slave bus
);

  localparam int N  = ROWS * COLS;
  localparam int AW = calc_aw(N);

  logic [1:0]    full_q, full_d;
  logic          wrBank_q, wrBank_d;
  logic          rdBank_q, rdBank_d;
  logic [AW-1:0] wrCnt_q, wrCnt_d;
  logic [1:0]    bankMode_q, bankMode_d;
  logic          outValid_q, outValid_d;
  logic          outSof_q, outSof_d;
  logic          syncErr_q, syncErr_d;

  logic          inReady, wrEn, rdEn, resync, wrLast;
  logic          rdFirst, rdLast;
  logic [AW-1:0] rdAddr;

  assign inReady = ~full_q[wrBank_q];
  assign wrEn    = bus.in_valid & inReady;
  assign resync  = wrEn & bus.in_sof & (wrCnt_q != '0);
  assign wrLast  = wrEn & ~resync & (wrCnt_q == AW'(N - 1));
  assign rdEn    = full_q[rdBank_q] & (~outValid_q | bus.out_ready);

  interleaver_rd_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW)
  ) u_rd_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (rdEn),
    .mode_i    (bankMode_q[rdBank_q]),
    .addr_o    (rdAddr),
    .first_o   (rdFirst),
    .last_o    (rdLast)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wrBank_q   <= 1'b0;
      rdBank_q   <= 1'b0;
      wrCnt_q    <= '0;
      bankMode_q <= '0;
      outValid_q <= 1'b0;
      outSof_q   <= 1'b0;
      syncErr_q  <= 1'b0;
    end else begin
      full_q     <= full_d;
      wrBank_q   <= wrBank_d;
      rdBank_q   <= rdBank_d;
      wrCnt_q    <= wrCnt_d;
      bankMode_q <= bankMode_d;
      outValid_q <= outValid_d;
      outSof_q   <= outSof_d;
      syncErr_q  <= syncErr_d;
    end
  end

  // A mid-frame start-of-frame restarts the current bank with this symbol at 0.
  always_comb begin
    full_d     = full_q;
    wrBank_d   = wrBank_q;
    rdBank_d   = rdBank_q;
    wrCnt_d    = wrCnt_q;
    bankMode_d = bankMode_q;
    outValid_d = outValid_q;
    outSof_d   = outSof_q;
    syncErr_d  = resync;

    if (wrEn) begin
      if (resync) begin
        wrCnt_d = AW'(1);
      end else if (wrLast) begin
        wrCnt_d          = '0;
        wrBank_d         = ~wrBank_q;
        full_d[wrBank_q] = 1'b1;
      end else begin
        wrCnt_d = wrCnt_q + AW'(1);
      end
      if (resync || (wrCnt_q == '0)) bankMode_d[wrBank_q] = bus.mode;
    end

    if (rdEn && rdLast) begin
      full_d[rdBank_q] = 1'b0;
      rdBank_d         = ~rdBank_q;
    end

    if (rdEn) begin
      outValid_d = 1'b1;
      outSof_d   = rdFirst;
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.wr_en     = wrEn;
  assign bus.wr_bank   = wrBank_q;
  assign bus.wr_addr   = resync ? '0 : wrCnt_q;
  assign bus.rd_en     = rdEn;
  assign bus.rd_bank   = rdBank_q;
  assign bus.rd_addr   = rdAddr;
  assign bus.out_valid = outValid_q;
  assign bus.out_sof   = outSof_q;
  assign bus.sync_err  = syncErr_q;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Scoreboard bench for interleaver_ctrl: a 4x4 instance with a behavioural
// bank memory and a 2x4 instance checked on its read address sequence.
module tb_interleaver_ctrl;
  import interleaver_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  interleaver_ctrl_if #(.AW(4)) bus4 ();
  interleaver_ctrl_if #(.AW(3)) bus2 ();

  interleaver_ctrl #(.ROWS(4), .COLS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  interleaver_ctrl #(.ROWS(2), .COLS(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int total = 0;
  int bad   = 0;

  int sym4;
  int mem4 [2][16];
  int rdData4;
  int expData4[$];
  bit expSof4[$];
  int expAddr4[$];
  int expAddr2[$];
  int ed4, ea4, ea2;
  bit es4;
  int syncHigh4 = 0;
  int run4 = 0;
  int maxRun4 = 0;

  int perm44 [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int perm24d [8] = '{0, 2, 4, 6, 1, 3, 5, 7};
  int perm24i [8] = '{0, 4, 1, 5, 2, 6, 3, 7};

  // Memory model and scoreboard for the 4x4 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus4.out_valid && !bus4.out_ready) begin
        total++;
        if (bus4.rd_en !== 1'b0) begin
          bad++;
          $display("[TB] FAIL stall_rd_en: rd_en=%b required 0", bus4.rd_en);
        end
      end
      if (bus4.out_valid && bus4.out_ready) begin
        total++;
        if (expData4.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_output: data=%0d with nothing expected", rdData4);
        end else begin
          ed4 = expData4.pop_front();
          es4 = expSof4.pop_front();
          if (rdData4 !== ed4 || bus4.out_sof !== es4) begin
            bad++;
            $display("[TB] FAIL out_data: data=%0d sof=%b required data=%0d sof=%b",
                     rdData4, bus4.out_sof, ed4, es4);
          end
        end
      end
      if (bus4.rd_en) begin
        total++;
        if (expAddr4.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_read4: rd_addr=%0d with nothing expected", bus4.rd_addr);
        end else begin
          ea4 = expAddr4.pop_front();
          if (bus4.rd_addr !== 4'(ea4)) begin
            bad++;
            $display("[TB] FAIL rd_addr4: got %0d required %0d", bus4.rd_addr, ea4);
          end
        end
        rdData4 = mem4[bus4.rd_bank][bus4.rd_addr];
      end
      if (bus4.wr_en) mem4[bus4.wr_bank][bus4.wr_addr] = sym4;
      if (bus4.sync_err) syncHigh4++;
      run4 = bus4.out_valid ? run4 + 1 : 0;
      if (run4 > maxRun4) maxRun4 = run4;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.rd_en) begin
      total++;
      if (expAddr2.size() == 0) begin
        bad++;
        $display("[TB] FAIL extra_read2: rd_addr=%0d with nothing expected", bus2.rd_addr);
      end else begin
        ea2 = expAddr2.pop_front();
        if (bus2.rd_addr !== 3'(ea2)) begin
          bad++;
          $display("[TB] FAIL rd_addr2: got %0d required %0d", bus2.rd_addr, ea2);
        end
      end
    end
  end

  task automatic do_reset;
    bus4.in_valid = 0; bus4.in_sof = 0; bus4.mode = 0; bus4.out_ready = 1;
    bus2.in_valid = 0; bus2.in_sof = 0; bus2.mode = 0; bus2.out_ready = 1;
    sym4 = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic push4(input int base);
    for (int i = 0; i < 16; i++) begin
      expAddr4.push_back(perm44[i]);
      expData4.push_back(base + perm44[i]);
      expSof4.push_back(i == 0);
    end
  endtask

  task automatic push2(input bit mode);
    for (int i = 0; i < 8; i++) expAddr2.push_back(mode ? perm24d[i] : perm24i[i]);
  endtask

  task automatic send4(input int base, input int firstAddr, input int count, input logic mode,
                       input bit sofFirst, output int stalls, output logic firstBank);
    stalls = 0;
    firstBank = 1'b0;
    for (int k = 0; k < count; k++) begin
      int waitN;
      waitN = 0;
      bus4.in_valid = 1;
      bus4.in_sof   = sofFirst && (k == 0);
      bus4.mode     = mode;
      sym4          = base + firstAddr + k;
      @(negedge clk);
      while (!bus4.in_ready && waitN < 200) begin
        stalls++; waitN++;
        @(negedge clk);
      end
      if (!bus4.in_ready) begin
        total++; bad++;
        $display("[TB] FAIL accept_timeout4: in_ready=0 required 1 within 200 cycles");
        bus4.in_valid = 0;
        return;
      end
      if (k == 0) firstBank = bus4.wr_bank;
      @(posedge clk); #1;
    end
    bus4.in_valid = 0;
    bus4.in_sof   = 0;
  endtask

  task automatic send2(input logic mode);
    for (int k = 0; k < 8; k++) begin
      int waitN;
      waitN = 0;
      bus2.in_valid = 1;
      bus2.in_sof   = (k == 0);
      bus2.mode     = mode;
      @(negedge clk);
      while (!bus2.in_ready && waitN < 200) begin
        waitN++;
        @(negedge clk);
      end
      if (!bus2.in_ready) begin
        total++; bad++;
        $display("[TB] FAIL accept_timeout2: in_ready=0 required 1 within 200 cycles");
        bus2.in_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    bus2.in_valid = 0;
    bus2.in_sof   = 0;
  endtask

  task automatic drain4(input string name);
    int n = 0;
    while (expData4.size() != 0 && n < 400) begin
      @(posedge clk); n++;
    end
    #1;
    total++;
    if (expData4.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain_%s: %0d outputs missing, required 0", name, expData4.size());
    end
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    total++;
    if ({bus4.in_ready, bus4.wr_en, bus4.rd_en, bus4.out_valid, bus4.out_sof,
         bus4.sync_err, bus4.wr_bank, bus4.rd_bank} !== 8'b1000_0000) begin
      bad++;
      $display("[TB] FAIL reset_flags4: got %b required 10000000",
               {bus4.in_ready, bus4.wr_en, bus4.rd_en, bus4.out_valid, bus4.out_sof,
                bus4.sync_err, bus4.wr_bank, bus4.rd_bank});
    end
    total++;
    if ({bus4.wr_addr, bus4.rd_addr} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_addr4: wr=%0d rd=%0d required 0 0", bus4.wr_addr, bus4.rd_addr);
    end
    total++;
    if ({bus2.in_ready, bus2.rd_en, bus2.out_valid, bus2.rd_addr} !== 6'b100_000) begin
      bad++;
      $display("[TB] FAIL reset_2x4: ready=%b rd_en=%b valid=%b rd_addr=%0d required 1 0 0 0",
               bus2.in_ready, bus2.rd_en, bus2.out_valid, bus2.rd_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ilv_4x4;
    int st;
    logic fb;
    do_reset;
    push4(0);
    send4(0, 0, 16, MODE_ILV, 1, st, fb);
    @(negedge clk);
    total++;
    if ({bus4.rd_en, bus4.out_valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL first_read: rd_en=%b out_valid=%b required 1 0", bus4.rd_en, bus4.out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({bus4.out_valid, bus4.out_sof} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL first_out: out_valid=%b out_sof=%b required 1 1", bus4.out_valid, bus4.out_sof);
    end
    @(posedge clk); #1;
    drain4("ilv");
  endtask

  task automatic test_2x4;
    int n = 0;
    do_reset;
    push2(1'b1);
    push2(1'b0);
    send2(MODE_DEILV);
    send2(MODE_ILV);
    while (expAddr2.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    total++;
    if (expAddr2.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain_2x4: %0d reads missing, required 0", expAddr2.size());
    end
  endtask

  task automatic test_back_to_back;
    int st [3];
    logic fb [3];
    do_reset;
    push4(100); push4(200); push4(300);
    maxRun4 = 0;
    send4(100, 0, 16, MODE_ILV,   1, st[0], fb[0]);
    send4(200, 0, 16, MODE_DEILV, 1, st[1], fb[1]);
    send4(300, 0, 16, MODE_ILV,   1, st[2], fb[2]);
    total++;
    if ((st[0] + st[1] + st[2]) !== 0) begin
      bad++;
      $display("[TB] FAIL b2b_stalls: got %0d stall cycles required 0", st[0] + st[1] + st[2]);
    end
    total++;
    if ({fb[0], fb[1], fb[2]} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL b2b_banks: got %b%b%b required 010", fb[0], fb[1], fb[2]);
    end
    drain4("b2b");
    total++;
    if (maxRun4 !== 48) begin
      bad++;
      $display("[TB] FAIL b2b_gapfree: longest out_valid run %0d required 48", maxRun4);
    end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    do_reset;
    bus4.out_ready = 0;
    push4(400); push4(500);
    bus4.in_valid = 1;
    bus4.mode = MODE_ILV;
    for (int i = 0; i < 100; i++) begin
      bus4.in_sof = ((acc % 16) == 0);
      sym4 = ((acc < 16) ? 400 : 500) + (acc % 16);
      @(negedge clk);
      if (!bus4.in_ready) break;
      acc++;
      @(posedge clk); #1;
    end
    total++;
    if (acc !== 32) begin
      bad++;
      $display("[TB] FAIL bp_accepted: got %0d symbols required 32", acc);
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if ({bus4.in_ready, bus4.out_valid, bus4.out_sof} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL bp_hold: ready=%b valid=%b sof=%b required 0 1 1",
               bus4.in_ready, bus4.out_valid, bus4.out_sof);
    end
    @(posedge clk); #1;
    bus4.in_valid = 0;
    bus4.in_sof = 0;
    bus4.out_ready = 1;
    drain4("bp");
  endtask

  task automatic test_resync;
    int st;
    logic fb;
    do_reset;
    syncHigh4 = 0;
    send4(50, 0, 9, MODE_ILV, 1, st, fb);
    push4(200);
    bus4.in_valid = 1; bus4.in_sof = 1; bus4.mode = MODE_ILV; sym4 = 200;
    @(negedge clk);
    total++;
    if ({bus4.in_ready, bus4.wr_en, bus4.wr_addr} !== 6'b11_0000) begin
      bad++;
      $display("[TB] FAIL resync_write: ready=%b wr_en=%b wr_addr=%0d required 1 1 0",
               bus4.in_ready, bus4.wr_en, bus4.wr_addr);
    end
    @(posedge clk); #1;
    bus4.in_valid = 0; bus4.in_sof = 0;
    @(negedge clk);
    total++;
    if (bus4.sync_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sync_err_pulse: got %b required 1", bus4.sync_err);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bus4.sync_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sync_err_end: got %b required 0", bus4.sync_err);
    end
    @(posedge clk); #1;
    send4(200, 1, 15, MODE_ILV, 0, st, fb);
    total++;
    if (fb !== 1'b0) begin
      bad++;
      $display("[TB] FAIL resync_bank: got %b required 0", fb);
    end
    drain4("resync");
    total++;
    if (syncHigh4 !== 1) begin
      bad++;
      $display("[TB] FAIL sync_err_count: high for %0d cycles required 1", syncHigh4);
    end
  endtask

  task automatic test_async_reset;
    int st;
    logic fb;
    do_reset;
    bus4.out_ready = 0;
    push4(600); push4(700);
    send4(600, 0, 16, MODE_ILV, 1, st, fb);
    send4(700, 0, 16, MODE_ILV, 1, st, fb);
    @(negedge clk);
    total++;
    if ({bus4.in_ready, bus4.out_valid} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL both_full: ready=%b valid=%b required 0 1", bus4.in_ready, bus4.out_valid);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({bus4.in_ready, bus4.wr_en, bus4.rd_en, bus4.out_valid, bus4.out_sof,
         bus4.sync_err, bus4.wr_bank, bus4.rd_bank, bus4.wr_addr, bus4.rd_addr} !== 16'h8000) begin
      bad++;
      $display("[TB] FAIL async_reset: got %h required 8000",
               {bus4.in_ready, bus4.wr_en, bus4.rd_en, bus4.out_valid, bus4.out_sof,
                bus4.sync_err, bus4.wr_bank, bus4.rd_bank, bus4.wr_addr, bus4.rd_addr});
    end
    expData4.delete(); expSof4.delete(); expAddr4.delete();
    @(posedge clk); #1;
    rst_n = 1;
    bus4.out_ready = 1;
    push4(800);
    send4(800, 0, 16, MODE_ILV, 1, st, fb);
    drain4("after_reset");
  endtask

  initial begin
    #2;
    test_reset;
    test_ilv_4x4;
    test_2x4;
    test_back_to_back;
    test_backpressure;
    test_resync;
    test_async_reset;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
